imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer that drives the instruction memory read port. It owns the fetch PC and captures the combinationally returned 32-bit instruction into a 2-entry prefetch buffer. It hands instructions to decode over a valid/ready handshake. Branch/jump redirects flush the buffer, and misaligned redirect targets trap into an error state.

## Interface
- PC_WIDTH, 32, width of fetch PC and memory byte address
- DATA_W, 32, instruction width (one word per fetch)
- RESET_PC, 0, fetch PC loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  reset, synchronous, active-high: asserted when 1, sampled on rising clk
- fetch_en  in  1  1 = fetching permitted; 0 = freeze fetch PC, no pushes
- redirect_valid  in  1  load new fetch PC this cycle (branch/jump/exception)
- redirect_pc  in  PC_WIDTH  redirect target byte address
- mem_addr  out  PC_WIDTH  byte address to instruction memory rd_addr; equals fetch_pc
- mem_data  in  DATA_W  instruction word returned combinationally for mem_addr
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DATA_W  head instruction
- out_pc  out  PC_WIDTH  byte address of head instruction
- misalign_err  out  1  sticky: last redirect target had redirect_pc[1:0] != 0

## Operation
- State machine: RUN, ERR. Reset -> RUN.
- Buffer: 2 entries of {pc, instr}, FIFO order, count 0..2. out_* reflect the head; out_valid = (count != 0).
- pop = out_valid & out_ready; a transfer completes whenever pop = 1.
- RUN, no redirect: push = fetch_en & (count < 2 | pop). The push captures {fetch_pc, mem_data}, and fetch_pc <= fetch_pc + 4. Simultaneous pop+push at count 2 or count 1 keeps count unchanged.
- fetch_pc wraps modulo 2^PC_WIDTH: 0xFFFFFFFC + 4 = 0x00000000. No flag.
- Redirect (any state) has priority over push:
  - The buffer is cleared (count <= 0), even if a pop completes in the same cycle; that pop still counts as consumed.
  - No push occurs that cycle.
- Aligned redirect target (redirect_pc[1:0] == 0):
  - fetch_pc <= redirect_pc.
  - misalign_err <= 0.
  - State -> RUN.
- Misaligned redirect target:
  - fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - misalign_err <= 1.
  - State -> ERR.
- ERR: no pushes, out_valid = 0. Stays in ERR until an aligned redirect.
- fetch_en = 0: no pushes, fetch_pc held. Pops continue draining the buffer.
- mem_addr = fetch_pc combinationally in all states. The memory read has no side effects.
- Reset values:
  - fetch_pc = RESET_PC, so mem_addr = RESET_PC.
  - count = 0, out_valid = 0.
  - out_instr = 0, out_pc = 0 (entry storage cleared).
  - misalign_err = 0, state RUN.
- Reset mid-stream overrides redirect and handshake. Buffered entries are discarded.

## Timing
- Fetch-to-valid latency is 1 cycle: a push at edge N gives out_valid = 1 after edge N.
- Sustained throughput is 1 instruction/cycle with out_ready = 1, fetch_en = 1.
- out_ready = 0 back-pressure:
  - The buffer fills in 2 cycles, then fetch_pc holds.
  - When out_ready rises, the first pop and the refill push occur in the same cycle.
- Redirect sampled at edge N:
  - out_valid = 0 after edge N.
  - The first target instruction is pushed at edge N+1 and visible after N+1.
  - Redirect penalty is 1 bubble.
- Back-to-back redirects: each one restarts the sequence. Only the last target is fetched.
- First cycle after reset deassert with fetch_en = 1: push of RESET_PC word; out_valid = 1 on the next cycle.
- All outputs are registered except mem_addr, which is driven directly from the fetch_pc register.

## Test plan
- Reset then stream: fetch_en = 1, out_ready = 1, memory words at 0x0/0x4/0x8 = 0x11111111/0x22222222/0x33333333.
  - Expect out_pc 0x0, 0x4, 0x8 on consecutive cycles with matching out_instr.
  - Expect out_valid first high 1 cycle after reset release.
- Back-pressure: out_ready = 0 for 5 cycles.
  - Expect count saturates at 2, mem_addr frozen at 0x8, out_pc stays 0x0.
  - Then out_ready = 1: 0x0, 0x4, 0x8, 0xC delivered with no loss or duplication.
- Redirect with full buffer and simultaneous pop: redirect_pc = 0x100.
  - Expect out_valid = 0 next cycle.
  - Expect out_pc = 0x100 the cycle after, and no old entry reappears.
- Misaligned redirect: redirect_pc = 0x202.
  - Expect misalign_err = 1, out_valid = 0 indefinitely, mem_addr = 0x200.
  - Then redirect_pc = 0x300: expect misalign_err = 0 and out_pc = 0x300 two cycles later.
- Wrap: redirect to 0xFFFFFFF8 with out_ready = 1.
  - Expect out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-stream: assert n_rst = 1 for 1 cycle while count = 2.
  - Expect out_valid = 0, misalign_err = 0, mem_addr = RESET_PC the next cycle.
  - Expect restart from RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers up to two fetched
// {pc, instr} pairs and hands them to decode over a valid/ready handshake.
module imem_fetch_ctrl #(
    parameter int                PC_WIDTH = 32,
    parameter int                DATA_W   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                misalign_err,
    output logic                fsm_state
);

    // Handshake: a transfer completes on every rising edge where
    // out_valid and out_ready are both 1; out_valid never depends on out_ready.

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [1:0]          count, count_nxt;
    logic                err_nxt;
    logic                pop, push;

    logic [PC_WIDTH-1:0] head_pc, tail_pc;
    logic [DATA_W-1:0]   head_instr, tail_instr;

    assign mem_addr  = fetch_pc;
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
    assign fsm_state = state;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        count_nxt    = count;
        err_nxt      = misalign_err;
        push         = 1'b0;
        pop          = out_valid & out_ready;

        if (redirect_valid) begin
            // A pop in this cycle is still consumed; the buffer simply empties.
            count_nxt = 2'd0;
            if (redirect_pc[1:0] == 2'b00) begin
                fetch_pc_nxt = redirect_pc;
                err_nxt      = 1'b0;
                state_nxt    = RUN;
            end else begin
                fetch_pc_nxt = {redirect_pc[PC_WIDTH-1:2], 2'b00};
                err_nxt      = 1'b1;
                state_nxt    = ERR;
            end
        end else begin
            case (state)
                RUN: begin
                    push      = fetch_en & ((count != 2'd2) | pop);
                    count_nxt = count + {1'b0, push} - {1'b0, pop};
                    if (push) begin
                        fetch_pc_nxt = fetch_pc + PC_WIDTH'(4);
                    end
                end
                default: begin
                    count_nxt = count - {1'b0, pop};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state        <= RUN;
            fetch_pc     <= RESET_PC;
            count        <= 2'd0;
            out_valid    <= 1'b0;
            misalign_err <= 1'b0;
            head_pc      <= '0;
            head_instr   <= '0;
            tail_pc      <= '0;
            tail_instr   <= '0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= fetch_pc_nxt;
            count        <= count_nxt;
            out_valid    <= (count_nxt != 2'd0);
            misalign_err <= err_nxt;
            // Head is entry 0; a pop shifts the tail forward into the head.
            if (!redirect_valid) begin
                if (pop) begin
                    if (count == 2'd2) begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        if (push) begin
                            tail_pc    <= fetch_pc;
                            tail_instr <= mem_data;
                        end
                    end else if (push) begin
                        head_pc    <= fetch_pc;
                        head_instr <= mem_data;
                    end
                end else if (push) begin
                    if (count == 2'd0) begin
                        head_pc    <= fetch_pc;
                        head_instr <= mem_data;
                    end else begin
                        tail_pc    <= fetch_pc;
                        tail_instr <= mem_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a per-cycle vector table plus short
// hand-written sequences for back-to-back redirects and a randomised drain.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic        fsm_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    imem_fetch_ctrl #(.PC_WIDTH(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err),
        .fsm_state      (fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11111111;
        return {a[15:0], ~a[31:16]};
    endfunction

    assign mem_data = mem_word(mem_addr);

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        chk_head;
        logic [31:0] epc;
        logic        eerr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fe, input logic rdy,
                                input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic chk_head,
                                input logic [31:0] epc, input logic eerr,
                                input logic [31:0] eaddr);
        vec_t v;
        v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.chk_head = chk_head; v.epc = epc; v.eerr = eerr; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic fe, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        n_rst          = rst;
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    initial begin
        int popped;
        int waited;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        //            rst fe rdy rv rpc           ev chk epc           err addr
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h4));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h4,        0, 32'h8));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h8,        0, 32'hC));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h4));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h4,        0, 32'hC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h8,        0, 32'h10));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'hC,        0, 32'h14));
        vecs.push_back(mk(0, 1, 1, 1, 32'h100,      0, 0, 32'h0,        0, 32'h100));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h104));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h108));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h104,      0, 32'h10C));
        vecs.push_back(mk(0, 1, 1, 1, 32'h202,      0, 0, 32'h0,        1, 32'h200));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h200));
        vecs.push_back(mk(0, 1, 1, 1, 32'h300,      0, 0, 32'h0,        0, 32'h300));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h300,      0, 32'h304));
        vecs.push_back(mk(0, 1, 1, 1, 32'hFFFFFFF8, 0, 0, 32'h0,        0, 32'hFFFFFFF8));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'hFFFFFFF8, 0, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h4));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h4,        0, 32'h8));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h8,        0, 32'hC));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h10));
        vecs.push_back(mk(1, 1, 1, 1, 32'h203,      0, 1, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h4));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            step();
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].eerr});
            check($sformatf("v%0d_state", i), {31'b0, fsm_state}, {31'b0, vecs[i].eerr});
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].eaddr);
            if (vecs[i].chk_head) begin
                check($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
                check($sformatf("v%0d_instr", i), out_instr,
                      vecs[i].ev ? mem_word(vecs[i].epc) : 32'h0);
            end
        end

        // back-to-back redirects: only the last target is fetched
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
        step();
        check("b2b_valid", {31'b0, out_valid}, 32'h0);
        check("b2b_addr", mem_addr, 32'h500);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check("b2b_pc0", out_pc, 32'h500);
        step();
        check("b2b_pc1", out_pc, 32'h504);
        check("b2b_instr1", out_instr, mem_word(32'h504));

        // bounded wait for first valid after a redirect
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h600);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        waited = 0;
        while (!out_valid && waited < 8) begin
            step();
            waited++;
        end
        check("redir_latency", waited, 1);
        check("redir_pc", out_pc, 32'h600);

        // scoreboard drain with random back-pressure and fetch gating
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1000);
        step();
        for (int k = 0; k < 64; k++) exp_q.push_back(32'h1000 + 32'(4 * k));
        popped = 0;
        for (int c = 0; c < 80; c++) begin
            drive(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 1'b0, 32'h0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", out_instr, mem_word(e));
                popped++;
            end
            step();
        end
        if (popped == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_progress actual=%0d required>0", popped);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
